// File: rtl/riscv_multicycle_ctrl_if.sv
// Control-sequencer bus: memory handshakes, decoder control fields and
// the per-cycle strobes the sequencer issues toward PC, IR and register file.
interface riscv_multicycle_ctrl_if;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_we;
    logic       dec_valid;
    logic [1:0] dec_wb_sel;
    logic       dec_rf_wen;
    logic       dec_mem_wen;
    logic [1:0] dec_pc_sel;
    logic       br_eq;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       retire;
    logic       halt;
    logic       fault;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               retire, halt, fault,
        input  imem_ack, dec_valid, dec_wb_sel, dec_rf_wen, dec_mem_wen,
               dec_pc_sel, br_eq, dmem_ack
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               retire, halt, fault,
        output imem_ack, dec_valid, dec_wb_sel, dec_rf_wen, dec_mem_wen,
               dec_pc_sel, br_eq, dmem_ack
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// saturating memory-handshake timeout that parks the core in a sticky HALT.
module riscv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input logic                     clk,
    input logic                     rst_n,
    riscv_multicycle_ctrl_if.master bus
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    localparam logic [1:0] PC_PLUS4    = 2'd0;
    localparam logic [1:0] PC_B_TARGET = 2'd1;
    localparam logic [1:0] WB_MEM      = 2'd1;
    localparam logic       MEM_WRITE   = 1'b1;
    localparam logic       RF_WRITE    = 1'b1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             fault_q;
    logic             tmo_hit;
    logic             tmo_fire;
    logic             cnt_clr;
    logic             cnt_inc;

    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       retire;

    assign tmo_hit = TMO_EN && (cnt == CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state <= state_next;
            if (tmo_fire) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        tmo_fire   = 1'b0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        retire     = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                // An ack landing on the limit cycle still completes the fetch.
                if (bus.imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = HALT;
                end
            end
            DECODE: state_next = bus.dec_valid ? EXEC : HALT;
            EXEC: begin
                if (bus.dec_mem_wen == MEM_WRITE || bus.dec_wb_sel == WB_MEM) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (bus.dec_mem_wen == MEM_WRITE);
                if (bus.dmem_ack) begin
                    state_next = WB;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = HALT;
                end
            end
            WB: begin
                rf_we  = (bus.dec_rf_wen == RF_WRITE);
                pc_we  = 1'b1;
                retire = 1'b1;
                // Untaken branch falls through to the sequential PC.
                if (bus.dec_pc_sel == PC_B_TARGET && !bus.br_eq) begin
                    pc_src = PC_PLUS4;
                end else begin
                    pc_src = bus.dec_pc_sel;
                end
                state_next = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign cnt_clr = (state_next != state) && (state_next == FETCH || state_next == MEM);
    assign cnt_inc = (state == FETCH && !bus.imem_ack) || (state == MEM && !bus.dmem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.rf_we    = rf_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_src   = pc_src;
    assign bus.retire   = retire;
    assign bus.halt     = (state == HALT);
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized bench for riscv_multicycle_ctrl: an instruction-level timeline
// model predicts every output on every cycle from the decoder fields and waits.
module tb_riscv_multicycle_ctrl;
    localparam int TMO = 4;
    localparam logic [1:0] PC_PLUS4    = 2'd0;
    localparam logic [1:0] PC_B_TARGET = 2'd1;
    localparam logic [1:0] WB_ALU      = 2'd0;
    localparam logic [1:0] WB_MEM      = 2'd1;
    localparam logic       MEM_WRITE   = 1'b1;
    localparam logic       RF_WRITE    = 1'b1;
    localparam logic [10:0] ZERO = 11'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    riscv_multicycle_ctrl_if ifc();

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    wire [10:0] observed = {ifc.imem_req, ifc.ir_we, ifc.dmem_req, ifc.dmem_we,
                            ifc.rf_we, ifc.pc_we, ifc.retire, ifc.halt, ifc.fault,
                            ifc.pc_src};

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ireq,irwe,dreq,dwe,rfwe,pcwe,ret,halt,fault,src}=%b expected %b",
                     tag, got, exp);
        end
    endtask

    function automatic logic [10:0] vec(input logic ireq, input logic irwe, input logic dreq,
                                        input logic dwe, input logic rfwe, input logic pcwe,
                                        input logic ret, input logic hlt, input logic flt,
                                        input logic [1:0] src);
        return {ireq, irwe, dreq, dwe, rfwe, pcwe, ret, hlt, flt, src};
    endfunction

    // One clock: drive acks at the falling edge, compare once they settle.
    task automatic cyc(input string tag, input logic iack, input logic dack, input logic [10:0] exp);
        @(negedge clk);
        ifc.imem_ack = iack;
        ifc.dmem_ack = dack;
        #1;
        check_eq(tag, observed, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.imem_ack = 1'b0;
        ifc.dmem_ack = 1'b0;
        #1;
        check_eq("reset_async", observed, ZERO);
        repeat (2) @(negedge clk);
        check_eq("reset_hold", observed, ZERO);
        rst_n = 1'b1;
        #1;
        check_eq("idle", observed, ZERO);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Plays one instruction; returns halted=1 when the core ends in HALT.
    task automatic run_instr(input int fw, input int mw, input logic valid,
                             input logic [1:0] wb, input logic rf, input logic mem,
                             input logic [1:0] pc, input logic br, output logic halted);
        logic       is_mem;
        logic [1:0] src;
        int         nf;
        int         nm;
        halted = 1'b0;
        is_mem = (mem == MEM_WRITE) || (wb == WB_MEM);
        // Decoder fields are junk until the IR is loaded.
        ifc.dec_valid   = rbit();
        ifc.dec_wb_sel  = 2'($urandom);
        ifc.dec_rf_wen  = rbit();
        ifc.dec_mem_wen = rbit();
        ifc.dec_pc_sel  = 2'($urandom);
        ifc.br_eq       = rbit();
        nf = (fw > TMO) ? TMO + 1 : fw;
        for (int i = 0; i < nf; i++)
            cyc("fetch_wait", 1'b0, rbit(), vec(1,0,0,0,0,0,0,0,0,PC_PLUS4));
        if (fw > TMO) begin
            for (int i = 0; i < 3; i++)
                cyc("fetch_timeout_halt", rbit(), rbit(), vec(0,0,0,0,0,0,0,1,1,PC_PLUS4));
            halted = 1'b1;
            return;
        end
        cyc("fetch_ack", 1'b1, rbit(), vec(1,1,0,0,0,0,0,0,0,PC_PLUS4));
        ifc.dec_valid   = valid;
        ifc.dec_wb_sel  = wb;
        ifc.dec_rf_wen  = rf;
        ifc.dec_mem_wen = mem;
        ifc.dec_pc_sel  = pc;
        ifc.br_eq       = br;
        cyc("decode", rbit(), rbit(), ZERO);
        if (!valid) begin
            for (int i = 0; i < 3; i++)
                cyc("illegal_halt", rbit(), rbit(), vec(0,0,0,0,0,0,0,1,0,PC_PLUS4));
            halted = 1'b1;
            return;
        end
        cyc("exec", rbit(), rbit(), ZERO);
        if (is_mem) begin
            nm = (mw > TMO) ? TMO + 1 : mw;
            for (int i = 0; i < nm; i++)
                cyc("mem_wait", rbit(), 1'b0, vec(0,0,1,mem == MEM_WRITE,0,0,0,0,0,PC_PLUS4));
            if (mw > TMO) begin
                for (int i = 0; i < 3; i++)
                    cyc("mem_timeout_halt", rbit(), rbit(), vec(0,0,0,0,0,0,0,1,1,PC_PLUS4));
                halted = 1'b1;
                return;
            end
            cyc("mem_ack", rbit(), 1'b1, vec(0,0,1,mem == MEM_WRITE,0,0,0,0,0,PC_PLUS4));
        end
        src = (pc == PC_B_TARGET && !br) ? PC_PLUS4 : pc;
        cyc("writeback", rbit(), rbit(), vec(0,0,0,0,rf == RF_WRITE,1,1,0,0,src));
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 19) == 0) ? $urandom_range(TMO + 1, TMO + 2)
                                            : $urandom_range(0, TMO);
    endfunction

    initial begin
        logic halted;
        ifc.imem_ack = 1'b0;
        ifc.dmem_ack = 1'b0;
        ifc.dec_valid = 1'b0;
        ifc.dec_wb_sel = 2'd0;
        ifc.dec_rf_wen = 1'b0;
        ifc.dec_mem_wen = 1'b0;
        ifc.dec_pc_sel = 2'd0;
        ifc.br_eq = 1'b0;
        #2;
        do_reset();

        run_instr(0, 0, 1, WB_ALU, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);     // add
        run_instr(0, 3, 1, WB_MEM, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);     // lw
        run_instr(0, 0, 1, WB_ALU, 1'b0, MEM_WRITE, PC_PLUS4, 1'b0, halted);    // sw
        run_instr(0, 0, 1, WB_ALU, 1'b0, 1'b0, PC_B_TARGET, 1'b1, halted);      // beq taken
        run_instr(1, 0, 1, WB_ALU, 1'b0, 1'b0, PC_B_TARGET, 1'b0, halted);      // beq not taken
        run_instr(TMO, 0, 1, WB_ALU, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);   // ack on limit
        run_instr(0, TMO, 1, WB_MEM, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);
        run_instr(0, 0, 0, WB_ALU, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);     // illegal
        do_reset();
        run_instr(TMO + 3, 0, 1, WB_ALU, RF_WRITE, 1'b0, PC_PLUS4, 1'b0, halted);
        do_reset();
        run_instr(0, TMO + 1, 1, WB_ALU, 1'b0, MEM_WRITE, PC_PLUS4, 1'b0, halted);
        do_reset();
        // Reset in the middle of an outstanding fetch.
        cyc("fetch_wait_pre_reset", 1'b0, 1'b0, vec(1,0,0,0,0,0,0,0,0,PC_PLUS4));
        cyc("fetch_wait_pre_reset", 1'b0, 1'b0, vec(1,0,0,0,0,0,0,0,0,PC_PLUS4));
        do_reset();

        for (int k = 0; k < 300; k++) begin
            run_instr(pick_wait(), pick_wait(), ($urandom_range(0, 24) != 0),
                      2'($urandom), rbit(), rbit(), 2'($urandom), rbit(), halted);
            if (halted) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
